// File: rtl/pipe_stage_buf.sv
// Elastic pipeline stage: main + skid entry behind a valid/ready handshake, flushable.
// Define PIPE_STAGE_PERF_EN to add the saturating back-pressure counter stall_cnt_o.
module pipe_stage_buf #(
    parameter int DATA_W   = 32,
    parameter int NUM_DATA = 2,
    parameter int RD_W     = 5,
    parameter int CTRL_W   = 4
`ifdef PIPE_STAGE_PERF_EN
    ,
    parameter int CNT_W    = 16
`endif
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [NUM_DATA*DATA_W-1:0] in_data_i,
    input  logic [RD_W-1:0]            in_rd_i,
    input  logic [CTRL_W-1:0]          in_ctrl_i,
    input  logic                       flush_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [NUM_DATA*DATA_W-1:0] out_data_o,
    output logic [RD_W-1:0]            out_rd_o,
    output logic [CTRL_W-1:0]          out_ctrl_o
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]           stall_cnt_o
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b10
    } state_e;

    typedef struct packed {
        logic [NUM_DATA-1:0][DATA_W-1:0] data;
        logic [RD_W-1:0]                 rd;
        logic [CTRL_W-1:0]               ctrl;
    } entry_t;

    state_e state;
    entry_t inEntry, mainQ, skidQ;
    logic   push, pop;

    assign inEntry = {in_data_i, in_rd_i, in_ctrl_i};

    // Handshake flags come straight from the occupancy register: no in->out comb path.
    assign in_ready_o  = (state != FULL);
    assign out_valid_o = (state != EMPTY);
    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;

    assign out_data_o = mainQ.data;
    assign out_rd_o   = mainQ.rd;
    assign out_ctrl_o = out_valid_o ? mainQ.ctrl : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= EMPTY;
            mainQ <= '0;
            skidQ <= '0;
        end else if (flush_i) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: if (push) begin
                    mainQ <= inEntry;
                    state <= ONE;
                end
                ONE: begin
                    if (push && pop) begin
                        mainQ <= inEntry;
                    end else if (push) begin
                        skidQ <= inEntry;
                        state <= FULL;
                    end else if (pop) begin
                        state <= EMPTY;
                    end
                end
                FULL: if (pop) begin
                    mainQ <= skidQ;
                    state <= ONE;
                end
                default: state <= EMPTY;
            endcase
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    // Counts cycles the head is held by downstream; survives flush on purpose.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
        end else if (out_valid_o && !out_ready_i && (stall_cnt_o != {CNT_W{1'b1}})) begin
            stall_cnt_o <= stall_cnt_o + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench for pipe_stage_buf: FIFO-of-depth-2 reference model, directed plus random traffic.
module tb_pipe_stage_buf;
    localparam int DATA_W   = 32;
    localparam int NUM_DATA = 2;
    localparam int RD_W     = 5;
    localparam int CTRL_W   = 4;
`ifdef PIPE_STAGE_PERF_EN
    localparam int CNT_W    = 3;
`endif

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic                       in_valid = 1'b0, in_ready, flush = 1'b0;
    logic [NUM_DATA*DATA_W-1:0] in_data = '0, out_data;
    logic [RD_W-1:0]            in_rd = '0, out_rd;
    logic [CTRL_W-1:0]          in_ctrl = '0, out_ctrl;
    logic                       out_valid, out_ready = 1'b0;
`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0]           stall_cnt;
    int                         expCnt = 0;
`endif

    typedef struct packed {
        logic [NUM_DATA*DATA_W-1:0] data;
        logic [RD_W-1:0]            rd;
        logic [CTRL_W-1:0]          ctrl;
    } ent_t;

    ent_t q[$];
    int   preSize = 0;
    int   checks = 0, passes = 0;

    pipe_stage_buf #(
        .DATA_W(DATA_W), .NUM_DATA(NUM_DATA), .RD_W(RD_W), .CTRL_W(CTRL_W)
`ifdef PIPE_STAGE_PERF_EN
        , .CNT_W(CNT_W)
`endif
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_data_i(in_data), .in_rd_i(in_rd), .in_ctrl_i(in_ctrl),
        .flush_i(flush),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_data_o(out_data), .out_rd_o(out_rd), .out_ctrl_o(out_ctrl)
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cnt_o(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: occupancy-derived handshake, head-of-queue contents, bubbles.
    always @(negedge clk) begin
        preSize = q.size();
        chk("out_valid", {127'd0, out_valid}, {127'd0, preSize != 0});
        chk("in_ready", {127'd0, in_ready}, {127'd0, preSize < 2});
        if (out_valid) begin
            if (q.size() > 0) begin
                chk("head", {55'd0, out_data, out_rd, out_ctrl}, {55'd0, q[0]});
                if (out_ready) void'(q.pop_front());
            end
        end else begin
            chk("bubble_ctrl", {124'd0, out_ctrl}, 128'd0);
        end
`ifdef PIPE_STAGE_PERF_EN
        chk("stall_cnt", {125'd0, stall_cnt}, expCnt);
`endif
    end

    // Reference model: two-deep FIFO; flush and reset empty it, reset wins.
    always @(posedge clk) begin
        if (rst) begin
            q.delete();
`ifdef PIPE_STAGE_PERF_EN
            expCnt = 0;
`endif
        end else begin
`ifdef PIPE_STAGE_PERF_EN
            if (preSize > 0 && !out_ready && expCnt < (1 << CNT_W) - 1) expCnt++;
`endif
            if (flush) q.delete();
            else if (in_valid && preSize < 2) q.push_back({in_data, in_rd, in_ctrl});
        end
    end

    task automatic cyc(input bit v, input logic [63:0] d, input logic [4:0] r,
                       input logic [3:0] c, input bit ordy, input bit fl);
        in_valid = v; in_data = d; in_rd = r; in_ctrl = c; out_ready = ordy; flush = fl;
        @(posedge clk); #1;
    endtask

    task automatic chkZeroHead();
        @(negedge clk);
        chk("rst_data", {64'd0, out_data}, 128'd0);
        chk("rst_rd", {123'd0, out_rd}, 128'd0);
        @(posedge clk); #1;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    initial begin
        rst = 1'b1;
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        chkZeroHead();

        // single entry then a bubble
        cyc(1, {32'h22222222, 32'h11111111}, 5'd5, 4'b0110, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);

        // back-to-back stream
        for (int i = 0; i < 8; i++) cyc(1, rnd64(), 5'(i), 4'($urandom), 1, 0);
        cyc(0, 0, 0, 0, 1, 0);

        // back-pressure: A in main, B in skid, C refused, then drain
        cyc(1, 64'hAAAA, 5'd1, 4'hA, 0, 0);
        cyc(1, 64'hBBBB, 5'd2, 4'hB, 0, 0);
        cyc(1, 64'hCCCC, 5'd3, 4'hC, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);

        // flush while full with a concurrent push
        cyc(1, 64'h1111, 5'd4, 4'h1, 0, 0);
        cyc(1, 64'h2222, 5'd5, 4'h2, 0, 0);
        cyc(1, 64'h3333, 5'd6, 4'h3, 0, 1);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);

        // reset while full
        cyc(1, 64'h4444, 5'd7, 4'h4, 0, 0);
        cyc(1, 64'h5555, 5'd8, 4'h5, 0, 0);
        rst = 1'b1;
        cyc(0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        chkZeroHead();

`ifdef PIPE_STAGE_PERF_EN
        cyc(1, 64'h6666, 5'd9, 4'h6, 0, 0);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("stall_sat", {125'd0, stall_cnt}, 128'd7);
        @(posedge clk); #1;
        cyc(0, 0, 0, 0, 1, 0);
`endif

        // random traffic with occasional flush and reset
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom % 80 == 0);
            cyc($urandom % 4 != 0, rnd64(), 5'($urandom), 4'($urandom),
                $urandom % 4 != 0, $urandom % 25 == 0);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, 0);
        chk("drained", q.size(), 128'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
